llc_snoop_responder: RTL and testbench
======================================

# llc_snoop_responder

Snoop-side responder of the LLC. It accepts bus operations issued by other caches, looks the address up in the LLC tag/state array, and returns the snoop result (NOHIT/HIT/HITM). On a modified hit it pulls the line from L1 and writes it back on the bus. It applies the MESI downgrade or invalidate and forwards INVALIDATELINE to L1 where inclusivity requires it. It sits between the bus snoop port and the LLC tag array, beside the LLC's own request path, and uses the `LLC_defs` types throughout.

## Interface
Parameters come from `LLC_defs`: ASSOCIATIVITY=16, INDEX=14, BYTE_OFFSET=6, TAG_BITS=12. There are no local parameters.

- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- snp_valid  in  1  snoop request valid
- snp_ready  out  1  high only in IDLE with rst low
- snp_op  in  busOperation  snooped operation
- snp_addr  in  32  snooped address: tag [31:20], index [19:6], offset [5:0]
- lk_en  out  1  tag-array read strobe
- lk_index  out  INDEX  set to read
- lk_ways  in  cache [ASSOCIATIVITY]  set contents, valid exactly 1 cycle after lk_en
- upd_en  out  1  one-cycle state write strobe
- upd_index  out  INDEX  set to update
- upd_way  out  4  way to update
- upd_mesi  out  mesi_bits  new state
- l1_valid / l1_ready  out / in  1  L1 message handshake
- l1_msg  out  messages  L1 message
- l1_addr  out  32  line address for L1, offset zeroed
- bus_valid / bus_ready  out / in  1  writeback handshake
- bus_op_out  out  busOperation  always WRITE when bus_valid is high
- bus_addr_out  out  32  writeback line address, offset zeroed
- res_valid  out  1  one-cycle snoop result strobe
- res  out  snoopResults  snoop result
- multi_hit  out  1  sticky error; cleared only by rst

## Operation
- **States:** IDLE → LOOKUP → EVAL → {GETL → WB →} {INVL →} DONE → IDLE.
- **IDLE:** on snp_valid & snp_ready, latch snp_op and snp_addr.
- **LOOKUP:** lk_en=1 with lk_index = latched index.
- **EVAL:**
  - A way hits when valid=1, tag matches, and mesi≠INVALID.
  - If more than one way hits, the lowest way wins and multi_hit is set.
  - The action is chosen from the matched way's state.
- **Action table:**
  - READ, M: res=HITM; GETLINE; writeback; new state S.
  - READ, E or S: res=HIT; new state S; no messages.
  - RWIM, M: res=HITM; GETLINE; writeback; INVALIDATELINE; new state I.
  - RWIM, E or S: res=HIT; INVALIDATELINE; new state I.
  - INVALIDATE, S: res=NOHIT; INVALIDATELINE; new state I.
  - INVALIDATE, E or M: protocol violation. Treated like RWIM on the same state. multi_hit is not set.
  - WRITE or NOBUSOP, any state: res=NOHIT; no update.
  - Any miss: res=NOHIT; no update.
- **GETL:** l1_valid=1, l1_msg=GETLINE. Hold until l1_ready.
- **WB:** bus_valid=1, bus_op_out=WRITE. Hold until bus_ready.
- **INVL:** l1_valid=1, l1_msg=INVALIDATELINE. Hold until l1_ready.
- **Handshake outputs:** stable while valid is high and ready is low. A handshake completes in the cycle where valid & ready are both high.
- **DONE:**
  - res_valid=1 with res.
  - upd_en=1 only if the state changes. upd_mesi carries the new state, upd_way the matched way.
- **Idle values:** res=NORESULT, l1_msg=NOMESSAGE, bus_op_out=NOBUSOP whenever not driving.

## Timing
- **Reset values:** state IDLE; snp_ready=0; all valids, lk_en and upd_en = 0; res=NORESULT; l1_msg=NOMESSAGE; bus_op_out=NOBUSOP; multi_hit=0.
- **Reset mid-transaction:** the operation is abandoned. No upd_en and no res_valid are issued. snp_ready rises on the first clock after rst falls.
- **Latency:** accept at cycle T, lk_en at T+1, EVAL at T+2, DONE at T+3 when no messages are needed. Each handshake adds ≥1 cycle.
- **Throughput:** snp_ready=1 again at T+4 minimum; one snoop is in flight at a time.
- **Ordering:** GETLINE completes before the writeback; the writeback completes before INVALIDATELINE. res_valid and upd_en always coincide and come last.

## Test plan
1. Set 0x1159, way 3 = {tag 0x123, valid, E}. READ 0x12345678 → lk_index=0x1159 at T+1; res=HIT and upd {0x1159, 3, SHARED} at T+3; no l1/bus activity.
2. Same set, way 3 = M. READ → GETLINE with l1_addr=0x12345640; then bus WRITE 0x12345640 with bus_ready stalled 5 cycles, outputs held; then res=HITM, upd_mesi=SHARED.
3. Way 3 = M. RWIM → GETLINE, WRITE, INVALIDATELINE in order; res=HITM; upd_mesi=INVALID.
4. Way 7 = S. INVALIDATE → INVALIDATELINE; res=NOHIT; upd_mesi=INVALID. Then WRITE to a miss address → res=NOHIT, no upd_en.
5. Ways 2 and 9 both match in valid state → way 2 is used; multi_hit=1 and stays set until rst.
6. Assert rst during the WB stall → bus_valid drops asynchronously; no res_valid; snp_ready=1 the cycle after rst deasserts.

Source files
------------

// File: rtl/llc_snoop_responder_if.sv
// LLC shared types plus the snoop responder's bundled port: bus snoop request,
// tag-array lookup/update, L1 message channel, bus writeback and result.
package LLC_defs;
  localparam int ASSOCIATIVITY = 16;
  localparam int INDEX         = 14;
  localparam int BYTE_OFFSET   = 6;
  localparam int TAG_BITS      = 12;

  typedef enum logic [2:0] {NOBUSOP, READ, WRITE, INVALIDATE, RWIM} busOperation;
  typedef enum logic [1:0] {NOHIT, HIT, HITM, NORESULT} snoopResults;
  typedef enum logic [2:0] {NOMESSAGE, GETLINE, SENDLINE, INVALIDATELINE, EVICTLINE} messages;
  typedef enum logic [1:0] {INVALID, SHARED, EXCLUSIVE, MODIFIED} mesi_bits;

  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    mesi_bits            mesi;
  } cache;
endpackage

interface llc_snoop_responder_if;
  import LLC_defs::*;

  logic                           snp_valid;
  logic                           snp_ready;
  busOperation                    snp_op;
  logic [31:0]                    snp_addr;

  logic                           lk_en;
  logic [INDEX-1:0]               lk_index;
  cache [ASSOCIATIVITY-1:0]       lk_ways;

  logic                           upd_en;
  logic [INDEX-1:0]               upd_index;
  logic [3:0]                     upd_way;
  mesi_bits                       upd_mesi;

  logic                           l1_valid;
  logic                           l1_ready;
  messages                        l1_msg;
  logic [31:0]                    l1_addr;

  logic                           bus_valid;
  logic                           bus_ready;
  busOperation                    bus_op_out;
  logic [31:0]                    bus_addr_out;

  logic                           res_valid;
  snoopResults                    res;
  logic                           multi_hit;

  // Responder side
  modport slave (
    input  snp_valid, snp_op, snp_addr, lk_ways, l1_ready, bus_ready,
    output snp_ready, lk_en, lk_index, upd_en, upd_index, upd_way, upd_mesi,
           l1_valid, l1_msg, l1_addr, bus_valid, bus_op_out, bus_addr_out,
           res_valid, res, multi_hit
  );

  // Bus / tag array / L1 side
  modport master (
    output snp_valid, snp_op, snp_addr, lk_ways, l1_ready, bus_ready,
    input  snp_ready, lk_en, lk_index, upd_en, upd_index, upd_way, upd_mesi,
           l1_valid, l1_msg, l1_addr, bus_valid, bus_op_out, bus_addr_out,
           res_valid, res, multi_hit
  );
endinterface

// File: rtl/llc_snoop_responder.sv
// LLC snoop responder: looks up a snooped line, answers NOHIT/HIT/HITM, pulls and
// writes back modified data, applies the MESI downgrade and back-invalidates L1.
module llc_snoop_way_cmp
  import LLC_defs::*;
(
  input  cache                way_i,
  input  logic [TAG_BITS-1:0] tag_i,
  output logic                hit_o
);
  assign hit_o = way_i.valid && (way_i.tag == tag_i) && (way_i.mesi != INVALID);
endmodule

module llc_snoop_responder
  import LLC_defs::*;
(
  input  logic                  clk,
  input  logic                  rst,
  llc_snoop_responder_if.slave  sif
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_EVAL, S_GETL, S_WB, S_INVL, S_DONE
  } state_t;

  localparam int LINE_W = 32 - BYTE_OFFSET;

  state_t              state_q;
  busOperation         op_q;
  logic [LINE_W-1:0]   line_q;
  snoopResults         res_hold_q;
  logic                upd_hold_q;
  logic                inv_q;

  logic                snp_ready_q;
  logic                lk_en_q;
  logic [INDEX-1:0]    lk_index_q;
  logic                upd_en_q;
  logic [INDEX-1:0]    upd_index_q;
  logic [3:0]          upd_way_q;
  mesi_bits            upd_mesi_q;
  logic                l1_valid_q;
  messages             l1_msg_q;
  logic [31:0]         l1_addr_q;
  logic                bus_valid_q;
  busOperation         bus_op_q;
  logic [31:0]         bus_addr_q;
  logic                res_valid_q;
  snoopResults         res_q;
  logic                multi_hit_q;

  // Per-way hit detection
  logic [ASSOCIATIVITY-1:0] hit_vec;
  for (genvar w = 0; w < ASSOCIATIVITY; w++) begin : g_way
    llc_snoop_way_cmp u_cmp (
      .way_i (sif.lk_ways[w]),
      .tag_i (line_q[LINE_W-1 -: TAG_BITS]),
      .hit_o (hit_vec[w])
    );
  end

  logic        any_hit;
  logic        multi_d;
  logic [3:0]  hit_way;
  mesi_bits    hit_mesi;
  snoopResults res_d;
  mesi_bits    mesi_d;
  logic        upd_d;
  logic        getl_d;
  logic        inv_d;

  // Lowest hitting way wins; the action table is keyed on its state.
  always_comb begin
    any_hit = 1'b0;
    hit_way = '0;
    for (int w = ASSOCIATIVITY-1; w >= 0; w--) begin
      if (hit_vec[w]) begin
        any_hit = 1'b1;
        hit_way = 4'(w);
      end
    end
    multi_d  = |(hit_vec & (hit_vec - {{(ASSOCIATIVITY-1){1'b0}}, 1'b1}));
    hit_mesi = sif.lk_ways[hit_way].mesi;
    res_d    = NOHIT;
    mesi_d   = hit_mesi;
    getl_d   = 1'b0;
    inv_d    = 1'b0;
    if (any_hit) begin
      unique case (op_q)
        READ: begin
          res_d  = (hit_mesi == MODIFIED) ? HITM : HIT;
          getl_d = (hit_mesi == MODIFIED);
          mesi_d = SHARED;
        end
        RWIM, INVALIDATE: begin
          // INVALIDATE against E/M is a protocol violation; recover as RWIM.
          inv_d  = 1'b1;
          mesi_d = INVALID;
          if (op_q == INVALIDATE && hit_mesi == SHARED) begin
            res_d = NOHIT;
          end else begin
            res_d  = (hit_mesi == MODIFIED) ? HITM : HIT;
            getl_d = (hit_mesi == MODIFIED);
          end
        end
        default: ;
      endcase
    end
    upd_d = any_hit && (mesi_d != hit_mesi);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= NOBUSOP;
      line_q      <= '0;
      res_hold_q  <= NORESULT;
      upd_hold_q  <= 1'b0;
      inv_q       <= 1'b0;
      snp_ready_q <= 1'b0;
      lk_en_q     <= 1'b0;
      lk_index_q  <= '0;
      upd_en_q    <= 1'b0;
      upd_index_q <= '0;
      upd_way_q   <= '0;
      upd_mesi_q  <= INVALID;
      l1_valid_q  <= 1'b0;
      l1_msg_q    <= NOMESSAGE;
      l1_addr_q   <= '0;
      bus_valid_q <= 1'b0;
      bus_op_q    <= NOBUSOP;
      bus_addr_q  <= '0;
      res_valid_q <= 1'b0;
      res_q       <= NORESULT;
      multi_hit_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          snp_ready_q <= 1'b1;
          if (sif.snp_valid && snp_ready_q) begin
            op_q        <= sif.snp_op;
            line_q      <= sif.snp_addr[31:BYTE_OFFSET];
            snp_ready_q <= 1'b0;
            lk_en_q     <= 1'b1;
            lk_index_q  <= sif.snp_addr[BYTE_OFFSET +: INDEX];
            state_q     <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          lk_en_q <= 1'b0;
          state_q <= S_EVAL;
        end
        S_EVAL: begin
          multi_hit_q <= multi_hit_q | multi_d;
          res_hold_q  <= res_d;
          upd_hold_q  <= upd_d;
          inv_q       <= inv_d;
          upd_index_q <= line_q[INDEX-1:0];
          upd_way_q   <= hit_way;
          upd_mesi_q  <= mesi_d;
          l1_addr_q   <= {line_q, {BYTE_OFFSET{1'b0}}};
          bus_addr_q  <= {line_q, {BYTE_OFFSET{1'b0}}};
          if (getl_d) begin
            l1_valid_q <= 1'b1;
            l1_msg_q   <= GETLINE;
            state_q    <= S_GETL;
          end else if (inv_d) begin
            l1_valid_q <= 1'b1;
            l1_msg_q   <= INVALIDATELINE;
            state_q    <= S_INVL;
          end else begin
            res_valid_q <= 1'b1;
            res_q       <= res_d;
            upd_en_q    <= upd_d;
            state_q     <= S_DONE;
          end
        end
        S_GETL: begin
          if (sif.l1_ready) begin
            l1_valid_q  <= 1'b0;
            l1_msg_q    <= NOMESSAGE;
            bus_valid_q <= 1'b1;
            bus_op_q    <= WRITE;
            state_q     <= S_WB;
          end
        end
        S_WB: begin
          if (sif.bus_ready) begin
            bus_valid_q <= 1'b0;
            bus_op_q    <= NOBUSOP;
            if (inv_q) begin
              l1_valid_q <= 1'b1;
              l1_msg_q   <= INVALIDATELINE;
              state_q    <= S_INVL;
            end else begin
              res_valid_q <= 1'b1;
              res_q       <= res_hold_q;
              upd_en_q    <= upd_hold_q;
              state_q     <= S_DONE;
            end
          end
        end
        S_INVL: begin
          if (sif.l1_ready) begin
            l1_valid_q  <= 1'b0;
            l1_msg_q    <= NOMESSAGE;
            res_valid_q <= 1'b1;
            res_q       <= res_hold_q;
            upd_en_q    <= upd_hold_q;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          res_valid_q <= 1'b0;
          res_q       <= NORESULT;
          upd_en_q    <= 1'b0;
          snp_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sif.snp_ready    = snp_ready_q;
  assign sif.lk_en        = lk_en_q;
  assign sif.lk_index     = lk_index_q;
  assign sif.upd_en       = upd_en_q;
  assign sif.upd_index    = upd_index_q;
  assign sif.upd_way      = upd_way_q;
  assign sif.upd_mesi     = upd_mesi_q;
  assign sif.l1_valid     = l1_valid_q;
  assign sif.l1_msg       = l1_msg_q;
  assign sif.l1_addr      = l1_addr_q;
  assign sif.bus_valid    = bus_valid_q;
  assign sif.bus_op_out   = bus_op_q;
  assign sif.bus_addr_out = bus_addr_q;
  assign sif.res_valid    = res_valid_q;
  assign sif.res          = res_q;
  assign sif.multi_hit    = multi_hit_q;

endmodule

// File: tb/tb_llc_snoop_responder.sv
// Directed bench for llc_snoop_responder: expected L1/bus events and snoop results
// are queued when a snoop is issued and consumed as the DUT produces them.
module tb_llc_snoop_responder;
  import LLC_defs::*;

  logic clk;
  logic rst;
  llc_snoop_responder_if sif();

  llc_snoop_responder dut (.clk(clk), .rst(rst), .sif(sif));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          kind;   // 0 = L1 message, 1 = bus writeback
    logic [2:0]  code;
    logic [31:0] addr;
  } ev_t;

  typedef struct {
    logic [1:0]  res;
    logic        upd;
    logic [13:0] idx;
    logic [3:0]  way;
    logic [1:0]  mesi;
  } res_t;

  ev_t  ev_q[$];
  res_t res_q[$];

  int checks = 0;
  int errors = 0;

  cache [ASSOCIATIVITY-1:0] set_ways;
  logic [13:0] set_idx;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_set();
    set_ways = '0;
  endtask

  task automatic set_way(input int w, input logic [11:0] tag, input mesi_bits m);
    set_ways[w].valid = 1'b1;
    set_ways[w].tag   = tag;
    set_ways[w].mesi  = m;
  endtask

  task automatic push_l1(input messages m, input logic [31:0] a);
    ev_t e;
    e.kind = 0; e.code = m; e.addr = a;
    ev_q.push_back(e);
  endtask

  task automatic push_bus(input logic [31:0] a);
    ev_t e;
    e.kind = 1; e.code = WRITE; e.addr = a;
    ev_q.push_back(e);
  endtask

  task automatic push_res(input snoopResults r, input logic u, input logic [13:0] i,
                          input logic [3:0] w, input mesi_bits m);
    res_t x;
    x.res = r; x.upd = u; x.idx = i; x.way = w; x.mesi = m;
    res_q.push_back(x);
  endtask

  task automatic run_snoop(input busOperation op, input logic [31:0] addr, input int l1_stall,
                           input int bus_stall, input bit abort, input int exp_lat);
    int   l1_cnt;
    int   bus_cnt;
    bit   done;
    logic [13:0] idx_seen;
    res_t r;
    l1_cnt  = 0;
    bus_cnt = 0;
    done    = 1'b0;
    for (int i = 0; i < 20 && sif.snp_ready !== 1'b1; i++) @(negedge clk);
    check("snp_ready_idle", sif.snp_ready, 1);
    sif.snp_valid = 1'b1;
    sif.snp_op    = op;
    sif.snp_addr  = addr;
    @(posedge clk);
    #1 sif.snp_valid = 1'b0;
    @(negedge clk);
    check("lk_en", sif.lk_en, 1);
    check("lk_index", sif.lk_index, addr[19:6]);
    check("snp_ready_busy", sif.snp_ready, 0);
    idx_seen = sif.lk_index;
    @(posedge clk);
    #1 sif.lk_ways = (idx_seen == set_idx) ? set_ways : '0;
    for (int cyc = 2; cyc < 80 && !done; cyc++) begin
      @(negedge clk);
      sif.l1_ready  = 1'b0;
      sif.bus_ready = 1'b0;
      check("upd_without_res", sif.upd_en & ~sif.res_valid, 0);
      if (sif.res_valid) begin
        check("res_expected", res_q.size() > 0, 1);
        check("events_before_res", ev_q.size(), 0);
        if (exp_lat > 0) check("latency", cyc, exp_lat);
        if (res_q.size() > 0) begin
          r = res_q.pop_front();
          check("res", sif.res, r.res);
          check("upd_en", sif.upd_en, r.upd);
          if (r.upd) begin
            check("upd_index", sif.upd_index, r.idx);
            check("upd_way", sif.upd_way, r.way);
            check("upd_mesi", sif.upd_mesi, r.mesi);
          end
        end
        done = 1'b1;
      end else if (sif.l1_valid) begin
        check("l1_bus_excl", sif.bus_valid, 0);
        check("l1_event_pending", ev_q.size() > 0, 1);
        if (ev_q.size() > 0) begin
          check("l1_order", ev_q[0].kind, 0);
          check("l1_msg", sif.l1_msg, ev_q[0].code);
          check("l1_addr", sif.l1_addr, ev_q[0].addr);
          if (l1_cnt >= l1_stall) begin
            sif.l1_ready = 1'b1;
            void'(ev_q.pop_front());
            l1_cnt = 0;
          end else l1_cnt++;
        end
      end else if (sif.bus_valid) begin
        check("bus_event_pending", ev_q.size() > 0, 1);
        if (ev_q.size() > 0) begin
          check("bus_order", ev_q[0].kind, 1);
          check("bus_op", sif.bus_op_out, ev_q[0].code);
          check("bus_addr", sif.bus_addr_out, ev_q[0].addr);
        end
        if (abort && bus_cnt == 2) begin
          #2 rst = 1'b1;
          #1;
          check("rst_bus_valid", sif.bus_valid, 0);
          check("rst_bus_op", sif.bus_op_out, NOBUSOP);
          check("rst_l1_valid", sif.l1_valid, 0);
          check("rst_res_valid", sif.res_valid, 0);
          check("rst_snp_ready", sif.snp_ready, 0);
          @(posedge clk);
          @(negedge clk);
          rst = 1'b0;
          #1 check("ready_before_clk", sif.snp_ready, 0);
          @(posedge clk);
          #1 check("ready_after_rst", sif.snp_ready, 1);
          for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("abort_no_res", sif.res_valid, 0);
            check("abort_no_upd", sif.upd_en, 0);
          end
          check("multi_hit_cleared", sif.multi_hit, 0);
          ev_q.delete();
          done = 1'b1;
        end else if (bus_cnt >= bus_stall) begin
          sif.bus_ready = 1'b1;
          if (ev_q.size() > 0) void'(ev_q.pop_front());
          bus_cnt = 0;
        end else bus_cnt++;
      end
      @(posedge clk);
      #1 sif.lk_ways = '0;
    end
    check("snoop_completed", done, 1);
    if (done && !abort) begin
      @(negedge clk);
      check("res_valid_pulse", sif.res_valid, 0);
      check("upd_en_pulse", sif.upd_en, 0);
      check("res_idle", sif.res, NORESULT);
      check("l1_msg_idle", sif.l1_msg, NOMESSAGE);
      check("bus_op_idle", sif.bus_op_out, NOBUSOP);
      check("ready_again", sif.snp_ready, 1);
    end
  endtask

  localparam logic [31:0] LA  = 32'h1234_5678;
  localparam logic [31:0] LN  = 32'h1234_5640;
  localparam logic [13:0] IDX = 14'h1159;

  initial begin
    rst           = 1'b1;
    sif.snp_valid = 1'b0;
    sif.snp_op    = NOBUSOP;
    sif.snp_addr  = '0;
    sif.lk_ways   = '0;
    sif.l1_ready  = 1'b0;
    sif.bus_ready = 1'b0;
    set_idx       = IDX;
    clear_set();
    #1;
    check("reset_snp_ready", sif.snp_ready, 0);
    check("reset_lk_en", sif.lk_en, 0);
    check("reset_upd_en", sif.upd_en, 0);
    check("reset_l1_valid", sif.l1_valid, 0);
    check("reset_bus_valid", sif.bus_valid, 0);
    check("reset_res_valid", sif.res_valid, 0);
    check("reset_res", sif.res, NORESULT);
    check("reset_l1_msg", sif.l1_msg, NOMESSAGE);
    check("reset_bus_op", sif.bus_op_out, NOBUSOP);
    check("reset_multi_hit", sif.multi_hit, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // READ hitting E: downgrade to S, no messages, DONE at T+3
    clear_set(); set_way(3, 12'h123, EXCLUSIVE);
    push_res(HIT, 1'b1, IDX, 4'd3, SHARED);
    run_snoop(READ, LA, 0, 0, 1'b0, 3);

    // READ hitting S: no state change so no update
    clear_set(); set_way(3, 12'h123, SHARED);
    push_res(HIT, 1'b0, IDX, 4'd3, SHARED);
    run_snoop(READ, LA, 0, 0, 1'b0, 3);

    // READ hitting M with a stalled writeback
    clear_set(); set_way(3, 12'h123, MODIFIED);
    push_l1(GETLINE, LN); push_bus(LN);
    push_res(HITM, 1'b1, IDX, 4'd3, SHARED);
    run_snoop(READ, LA, 0, 5, 1'b0, 0);

    // RWIM hitting M: GETLINE, WRITE, INVALIDATELINE in order
    clear_set(); set_way(3, 12'h123, MODIFIED);
    push_l1(GETLINE, LN); push_bus(LN); push_l1(INVALIDATELINE, LN);
    push_res(HITM, 1'b1, IDX, 4'd3, INVALID);
    run_snoop(RWIM, LA, 2, 1, 1'b0, 0);

    // RWIM hitting S
    clear_set(); set_way(3, 12'h123, SHARED);
    push_l1(INVALIDATELINE, LN);
    push_res(HIT, 1'b1, IDX, 4'd3, INVALID);
    run_snoop(RWIM, LA, 0, 0, 1'b0, 0);

    // INVALIDATE hitting S in way 7; way 5 matches tag but is INVALID
    clear_set(); set_way(5, 12'h123, INVALID); set_way(7, 12'h123, SHARED);
    push_l1(INVALIDATELINE, LN);
    push_res(NOHIT, 1'b1, IDX, 4'd7, INVALID);
    run_snoop(INVALIDATE, LA, 1, 0, 1'b0, 0);

    // WRITE to a different set: miss
    push_res(NOHIT, 1'b0, IDX, 4'd0, INVALID);
    run_snoop(WRITE, 32'hABC0_0040, 0, 0, 1'b0, 3);

    // WRITE hitting M: no action at all
    clear_set(); set_way(3, 12'h123, MODIFIED);
    push_res(NOHIT, 1'b0, IDX, 4'd3, MODIFIED);
    run_snoop(WRITE, LA, 0, 0, 1'b0, 3);

    // INVALIDATE hitting E behaves as RWIM
    clear_set(); set_way(3, 12'h123, EXCLUSIVE);
    push_l1(INVALIDATELINE, LN);
    push_res(HIT, 1'b1, IDX, 4'd3, INVALID);
    run_snoop(INVALIDATE, LA, 0, 0, 1'b0, 0);
    check("no_multi_hit_yet", sif.multi_hit, 0);

    // Two matching ways: lowest (2) wins, multi_hit sticks
    clear_set(); set_way(2, 12'h123, EXCLUSIVE); set_way(9, 12'h123, SHARED);
    push_res(HIT, 1'b1, IDX, 4'd2, SHARED);
    run_snoop(READ, LA, 0, 0, 1'b0, 3);
    check("multi_hit_set", sif.multi_hit, 1);

    // Tag mismatch in the right set: miss, multi_hit still held
    clear_set(); set_way(3, 12'h124, MODIFIED);
    push_res(NOHIT, 1'b0, IDX, 4'd0, INVALID);
    run_snoop(READ, LA, 0, 0, 1'b0, 3);
    check("multi_hit_sticky", sif.multi_hit, 1);

    // Reset during the writeback stall
    clear_set(); set_way(3, 12'h123, MODIFIED);
    push_l1(GETLINE, LN); push_bus(LN);
    run_snoop(READ, LA, 0, 10, 1'b1, 0);
    check("no_leftover_res", res_q.size(), 0);

    // Normal operation after reset
    clear_set(); set_way(3, 12'h123, EXCLUSIVE);
    push_res(HIT, 1'b1, IDX, 4'd3, SHARED);
    run_snoop(READ, LA, 0, 0, 1'b0, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
